// File: rtl/wfg_mem_pkg.sv
// rtl/wfg_mem_pkg.sv - shared widths, WB FSM states and read tags for the SRAM bank arbiter
package wfg_mem_pkg;
  localparam int MEM_DW = 32;
  localparam int MEM_AW = 9;
  localparam int BANKS  = 2;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_REQ,
    WB_RD_WAIT,
    WB_ACK
  } wb_state_e;

  localparam logic OWNER_WB  = 1'b0;
  localparam logic OWNER_WFG = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic bank;
  } rd_tag_t;
endpackage

// File: rtl/wfg_mem_rd_pipe.sv
// rtl/wfg_mem_rd_pipe.sv - read-tag delay line; captures macro dout into WB or WFG read registers
module wfg_mem_rd_pipe
  import wfg_mem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  rd_tag_t           wb_tag,
  input  rd_tag_t           wfg_tag,
  input  logic [MEM_DW-1:0] dout0,
  input  logic [MEM_DW-1:0] dout1,
  output logic              wb_done,
  output logic [MEM_DW-1:0] wb_data,
  output logic              wfg_rvalid,
  output logic [MEM_DW-1:0] wfg_rdata
);
  // slot 0 carries the WB tag, slot 1 the WFG tag; both may be live in one cycle
  rd_tag_t           stage    [READ_LAT][2];
  logic [MEM_DW-1:0] cap_data [2];
  logic              wfg_cap;

  always_comb begin
    wb_done = 1'b0;
    wfg_cap = 1'b0;
    for (int s = 0; s < 2; s++) begin
      cap_data[s] = stage[READ_LAT-1][s].bank ? dout1 : dout0;
      if (stage[READ_LAT-1][s].valid) begin
        if (stage[READ_LAT-1][s].owner == OWNER_WFG) wfg_cap = 1'b1;
        else wb_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        for (int s = 0; s < 2; s++) stage[i][s] <= '0;
      end
      wb_data    <= '0;
      wfg_rvalid <= 1'b0;
      wfg_rdata  <= '0;
    end else begin
      stage[0][0] <= wb_tag;
      stage[0][1] <= wfg_tag;
      for (int i = 1; i < READ_LAT; i++) begin
        for (int s = 0; s < 2; s++) stage[i][s] <= stage[i-1][s];
      end
      wfg_rvalid <= wfg_cap;
      for (int s = 0; s < 2; s++) begin
        if (stage[READ_LAT-1][s].valid) begin
          if (stage[READ_LAT-1][s].owner == OWNER_WFG) wfg_rdata <= cap_data[s];
          else wb_data <= cap_data[s];
        end
      end
    end
  end
endmodule

// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - shares two SRAM banks between the Wishbone slave and the WFG sample reader
module wb_mem_arbiter
  import wfg_mem_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              io_wbs_clk,
  input  logic              io_wbs_rst,
  input  logic [31:0]       io_wbs_adr,
  input  logic [MEM_DW-1:0] io_wbs_datwr,
  output logic [MEM_DW-1:0] io_wbs_datrd,
  input  logic              io_wbs_we,
  input  logic              io_wbs_stb,
  input  logic              io_wbs_cyc,
  output logic              io_wbs_ack,
  input  logic              wfg_req,
  input  logic [MEM_AW:0]   wfg_addr,
  output logic              wfg_gnt,
  output logic              wfg_rvalid,
  output logic [MEM_DW-1:0] wfg_rdata,
  output logic              csb_mem0,
  output logic              web_mem0,
  output logic [3:0]        wmask_mem0,
  output logic [MEM_AW-1:0] addr_mem0,
  output logic [MEM_DW-1:0] din_mem0,
  input  logic [MEM_DW-1:0] dout_mem0,
  output logic              csb_mem1,
  output logic              web_mem1,
  output logic [3:0]        wmask_mem1,
  output logic [MEM_AW-1:0] addr_mem1,
  output logic [MEM_DW-1:0] din_mem1,
  input  logic [MEM_DW-1:0] dout_mem1
);
  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  wb_state_e         state, state_n;
  logic [WW-1:0]     wait_cnt;
  logic              wb_pend, wb_bank, wfg_bank, conflict, wb_wins, wb_gnt, wb_done;
  logic [BANKS-1:0]  wb_on, wfg_on, csb, web;
  logic [3:0]        wmask [BANKS];
  logic [MEM_AW-1:0] addr  [BANKS];
  logic [MEM_DW-1:0] din   [BANKS];
  rd_tag_t           wb_tag, wfg_tag;
  logic              unused_adr;

  assign unused_adr = ^{io_wbs_adr[31:MEM_AW+3], io_wbs_adr[1:0]};

  // WFG wins same-bank conflicts until WB has lost MAX_WAIT consecutive cycles
  always_comb begin
    wb_bank  = io_wbs_adr[MEM_AW+2];
    wfg_bank = wfg_addr[MEM_AW];
    conflict = wb_pend && wfg_req && (wb_bank == wfg_bank);
    wb_wins  = (wait_cnt == WAIT_MAX);
    wb_gnt   = !io_wbs_rst && wb_pend && (!conflict || wb_wins);
    wfg_gnt  = !io_wbs_rst && wfg_req && !(conflict && wb_wins);
  end

  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      wb_on[b]  = wb_gnt && (wb_bank == 1'(b));
      wfg_on[b] = wfg_gnt && (wfg_bank == 1'(b));
      csb[b]    = !(wb_on[b] || wfg_on[b]);
      web[b]    = !(wb_on[b] && io_wbs_we);
      wmask[b]  = (wb_on[b] && io_wbs_we) ? 4'hF : 4'h0;
      addr[b]   = wb_on[b] ? io_wbs_adr[MEM_AW+1:2] :
                  (wfg_on[b] ? wfg_addr[MEM_AW-1:0] : '0);
      din[b]    = (wb_on[b] && io_wbs_we) ? io_wbs_datwr : '0;
    end
  end

  assign csb_mem0   = csb[0];
  assign web_mem0   = web[0];
  assign wmask_mem0 = wmask[0];
  assign addr_mem0  = addr[0];
  assign din_mem0   = din[0];
  assign csb_mem1   = csb[1];
  assign web_mem1   = web[1];
  assign wmask_mem1 = wmask[1];
  assign addr_mem1  = addr[1];
  assign din_mem1   = din[1];

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst || wb_gnt) wait_cnt <= '0;
    else if (conflict && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) state <= WB_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      WB_IDLE:    if (io_wbs_stb && io_wbs_cyc) state_n = WB_REQ;
      WB_REQ:     if (wb_gnt) state_n = io_wbs_we ? WB_ACK : WB_RD_WAIT;
      WB_RD_WAIT: if (wb_done) state_n = WB_ACK;
      WB_ACK:     state_n = WB_IDLE;
      default:    state_n = WB_IDLE;
    endcase
  end

  always_comb begin
    wb_pend    = (state == WB_REQ);
    io_wbs_ack = (state == WB_ACK);
  end

  always_comb begin
    wb_tag.valid  = wb_gnt && !io_wbs_we;
    wb_tag.owner  = OWNER_WB;
    wb_tag.bank   = wb_bank;
    wfg_tag.valid = wfg_gnt;
    wfg_tag.owner = OWNER_WFG;
    wfg_tag.bank  = wfg_bank;
  end

  wfg_mem_rd_pipe #(.READ_LAT(READ_LAT)) u_rd_pipe (
    .clk        (io_wbs_clk),
    .rst        (io_wbs_rst),
    .wb_tag     (wb_tag),
    .wfg_tag    (wfg_tag),
    .dout0      (dout_mem0),
    .dout1      (dout_mem1),
    .wb_done    (wb_done),
    .wb_data    (io_wbs_datrd),
    .wfg_rvalid (wfg_rvalid),
    .wfg_rdata  (wfg_rdata)
  );
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - directed self-checking bench for wb_mem_arbiter with behavioural SRAM banks
module tb_wb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, we, stb, cyc, wfg_req, preload;
  logic [31:0] adr, datwr;
  logic [9:0]  wfg_addr;
  logic [31:0] datrd, wfg_rdata, din0, din1, dout0, dout1;
  logic        ack, wfg_gnt, wfg_rvalid, csb0, csb1, web0, web1;
  logic [3:0]  wmask0, wmask1;
  logic [8:0]  addr0, addr1;
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst), .io_wbs_adr(adr), .io_wbs_datwr(datwr),
    .io_wbs_datrd(datrd), .io_wbs_we(we), .io_wbs_stb(stb), .io_wbs_cyc(cyc),
    .io_wbs_ack(ack), .wfg_req(wfg_req), .wfg_addr(wfg_addr), .wfg_gnt(wfg_gnt),
    .wfg_rvalid(wfg_rvalid), .wfg_rdata(wfg_rdata),
    .csb_mem0(csb0), .web_mem0(web0), .wmask_mem0(wmask0), .addr_mem0(addr0),
    .din_mem0(din0), .dout_mem0(dout0),
    .csb_mem1(csb1), .web_mem1(web1), .wmask_mem1(wmask1), .addr_mem1(addr1),
    .din_mem1(din1), .dout_mem1(dout1)
  );

  // single-cycle-read SRAM macros: inputs sampled at the clock edge, dout valid the next cycle
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) begin
        mem0[i] <= 32'(i * 3);
        mem1[i] <= 32'h1000_0000 + 32'(i);
      end
    end else begin
      if (!csb0) begin
        if (!web0) mem0[addr0] <= din0;
        else dout0 <= mem0[addr0];
      end
      if (!csb1) begin
        if (!web1) mem1[addr1] <= din1;
        else dout1 <= mem1[addr1];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    we = w; adr = a; datwr = d; stb = 1'b1; cyc = 1'b1;
  endtask

  task automatic wb_drop();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_dat, input string name);
    bit seen = 0;
    wb_drive(w, a, d);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (ack) begin
        seen = 1;
        chk({name, "_lat"}, 32'(c), 32'(exp_lat));
        if (!w) chk({name, "_data"}, datrd, exp_dat);
        wb_drop();
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: ack got none expected within 20 cycles", name);
      wb_drop();
    end
  endtask

  // WFG holds bank0 row 3 while WB reads bank0; WB must lose exactly 4 cycles
  task automatic conflict_round(input logic [31:0] a, input logic [31:0] exp_dat);
    wb_drive(1'b0, a, 32'h0);
    wfg_req = 1'b1; wfg_addr = 10'h003;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("t4_rvalid_k6", wfg_rvalid, 1);
        chk("t4_rdata_k6", wfg_rdata, 32'd9);
        chk("t4_ack_k6", ack, 0);
      end
      if (k == 7) begin
        chk("t4_ack", ack, 1);
        chk("t4_datrd", datrd, exp_dat);
        chk("t4_rvalid_k7", wfg_rvalid, 0);
        wb_drop(); wfg_req = 1'b0;
      end else begin
        #1;
        chk($sformatf("t4_gnt_k%0d", k), wfg_gnt, (k == 5) ? 0 : 1);
        chk($sformatf("t4_addr0_k%0d", k), addr0, (k == 5) ? 32'(a[10:2]) : 32'd3);
        chk($sformatf("t4_csb0_k%0d", k), csb0, 0);
      end
    end
  endtask

  typedef struct {
    logic        req;
    logic [9:0]  addr;
    logic        gnt;
    logic        csb0;
    logic        csb1;
    logic [8:0]  a0;
    logic [8:0]  a1;
    logic        rv;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 10'h000, 1'b1, 1'b0, 1'b1, 9'h000, 9'h000, 1'b1, 32'd0};
    tbl[1] = '{1'b1, 10'h005, 1'b1, 1'b0, 1'b1, 9'h005, 9'h000, 1'b1, 32'd15};
    tbl[2] = '{1'b1, 10'h200, 1'b1, 1'b1, 1'b0, 9'h000, 9'h000, 1'b1, 32'h1000_0000};
    tbl[3] = '{1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0, 9'h000, 9'h1FF, 1'b1, 32'h1000_01FF};
    tbl[4] = '{1'b1, 10'h1FF, 1'b1, 1'b0, 1'b1, 9'h1FF, 9'h000, 1'b1, 32'h0000_05FD};
    tbl[5] = '{1'b0, 10'h005, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, 1'b0, 32'd0};

    rst = 1'b1; preload = 1'b1; wfg_req = 1'b1; wfg_addr = 10'h0;
    adr = 32'h0; datwr = 32'h0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_gnt", wfg_gnt, 0);
    chk("rst_csb0", csb0, 1);
    chk("rst_csb1", csb1, 1);
    chk("rst_web0", web0, 1);
    chk("rst_wmask0", wmask0, 0);
    chk("rst_wmask1", wmask1, 0);
    chk("rst_addr0", addr0, 0);
    chk("rst_din0", din0, 0);
    chk("rst_ack", ack, 0);
    chk("rst_datrd", datrd, 0);
    chk("rst_rvalid", wfg_rvalid, 0);
    chk("rst_rdata", wfg_rdata, 0);
    rst = 1'b0; preload = 1'b0; wfg_req = 1'b0;

    // single WFG reads from the vector table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wfg_req = tbl[i].req; wfg_addr = tbl[i].addr;
      #1;
      chk($sformatf("v%0d_gnt", i), wfg_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_csb0", i), csb0, tbl[i].csb0);
      chk($sformatf("v%0d_csb1", i), csb1, tbl[i].csb1);
      chk($sformatf("v%0d_addr0", i), addr0, tbl[i].a0);
      chk($sformatf("v%0d_addr1", i), addr1, tbl[i].a1);
      @(negedge clk);
      wfg_req = 1'b0;
      chk($sformatf("v%0d_rvalid_t1", i), wfg_rvalid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid_t2", i), wfg_rvalid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("v%0d_rdata", i), wfg_rdata, tbl[i].rdata);
    end

    // test 5: WFG streams rows 0..7 of bank0 back-to-back
    @(negedge clk);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("t5_rvalid_c%0d", c), wfg_rvalid, (c >= 2 && c <= 9) ? 1 : 0);
      if (c >= 2 && c <= 9) chk($sformatf("t5_rdata_c%0d", c), wfg_rdata, 32'((c - 2) * 3));
      if (c < 8) begin
        wfg_req = 1'b1; wfg_addr = 10'(c);
        #1;
        chk($sformatf("t5_gnt_c%0d", c), wfg_gnt, 1);
      end else begin
        wfg_req = 1'b0;
      end
    end

    // test 1: WB write bank0 row 1
    @(negedge clk);
    wb_drive(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_csb0", csb0, 0);
    chk("t1_web0", web0, 0);
    chk("t1_addr0", addr0, 1);
    chk("t1_wmask0", wmask0, 4'hF);
    chk("t1_din0", din0, 32'hDEAD_BEEF);
    chk("t1_csb1", csb1, 1);
    chk("t1_ack_t", ack, 0);
    @(negedge clk);
    chk("t1_ack_t1", ack, 1);
    chk("t1_csb0_t1", csb0, 1);
    wb_drop();
    @(negedge clk);
    chk("t1_ack_t2", ack, 0);

    // test 2: WB read back the same word
    @(negedge clk);
    wb_drive(1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    chk("t2_csb0", csb0, 0);
    chk("t2_web0", web0, 1);
    chk("t2_wmask0", wmask0, 0);
    chk("t2_addr0", addr0, 1);
    @(negedge clk);
    chk("t2_ack_t1", ack, 0);
    @(negedge clk);
    chk("t2_ack_t2", ack, 1);
    chk("t2_datrd", datrd, 32'hDEAD_BEEF);
    wb_drop();
    @(negedge clk);
    chk("t2_ack_t3", ack, 0);

    // test 3: WB bank0 and WFG bank1 in the same cycle
    @(negedge clk);
    wb_drive(1'b0, 32'h0000_0008, 32'h0);
    @(negedge clk);
    wfg_req = 1'b1; wfg_addr = 10'h200;
    #1;
    chk("t3_gnt", wfg_gnt, 1);
    chk("t3_csb0", csb0, 0);
    chk("t3_addr0", addr0, 2);
    chk("t3_csb1", csb1, 0);
    @(negedge clk);
    wfg_req = 1'b0;
    chk("t3_ack_t1", ack, 0);
    chk("t3_rvalid_t1", wfg_rvalid, 0);
    @(negedge clk);
    chk("t3_ack_t2", ack, 1);
    chk("t3_datrd", datrd, 32'd6);
    chk("t3_rvalid_t2", wfg_rvalid, 1);
    chk("t3_rdata", wfg_rdata, 32'h1000_0000);
    wb_drop();

    // test 4: bounded WB wait, twice to show the wait count restarts
    @(negedge clk);
    conflict_round(32'h0000_0010, 32'd12);
    @(negedge clk);
    conflict_round(32'h0000_0014, 32'd15);

    // test 6: reset in the cycle after a read grant
    @(negedge clk); @(negedge clk);
    wb_drive(1'b0, 32'h0000_0004, 32'h0);
    @(negedge clk);
    wfg_req = 1'b1; wfg_addr = 10'h201;
    #1;
    chk("t6_gnt", wfg_gnt, 1);
    chk("t6_csb0_t", csb0, 0);
    chk("t6_csb1_t", csb1, 0);
    @(negedge clk);
    rst = 1'b1; wfg_req = 1'b0; wb_drop();
    #1;
    chk("t6_csb0_rst", csb0, 1);
    chk("t6_csb1_rst", csb1, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_ack_a", ack, 0);
    chk("t6_rvalid_a", wfg_rvalid, 0);
    chk("t6_datrd", datrd, 0);
    chk("t6_rdata", wfg_rdata, 0);
    @(negedge clk);
    chk("t6_ack_b", ack, 0);
    chk("t6_rvalid_b", wfg_rvalid, 0);
    @(negedge clk);
    wb_txn(1'b0, 32'h0000_0004, 32'h0, 3, 32'hDEAD_BEEF, "t6_reread");
    @(negedge clk);
    wb_txn(1'b1, 32'h0000_0808, 32'h1234_5678, 2, 32'h0, "t6_write_b1");
    @(negedge clk);
    wb_txn(1'b0, 32'h0000_0808, 32'h0, 3, 32'h1234_5678, "t6_read_b1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
